// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one magnitude comparator among NREQ requesters.
// Optional feature macro CMP_ARB_SIGNED_EN selects two's-complement operands (default: unsigned).
module cmp_share_arbiter #(
   parameter int  WIDTH = 4,
   parameter int  NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_greater,
   output logic                  rsp_equal,
   output logic                  rsp_less,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic [IDW-1:0]   winner;
   logic [IDW-1:0]   scan_idx;
   logic             found;

   // Shared comparator: {greater, equal, less}
   function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {a > b, a == b, a < b};
   endfunction

`ifdef CMP_ARB_SIGNED_EN
   // Flipping the sign bits maps two's-complement order onto unsigned order.
   localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);
   assign cmp_a = a_q ^ SIGN_BIT;
   assign cmp_b = b_q ^ SIGN_BIT;
`else
   assign cmp_a = a_q;
   assign cmp_b = b_q;
`endif

   // First asserted request at or after rr_ptr, wrapping NREQ-1 -> 0.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
         scan_idx = (scan_idx == IDW'(NREQ - 1)) ? '0 : scan_idx + IDW'(1);
      end
   end

   assign req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << winner) : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_greater <= 1'b0;
         rsp_equal   <= 1'b0;
         rsp_less    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  a_q    <= req_a[winner*WIDTH +: WIDTH];
                  b_q    <= req_b[winner*WIDTH +: WIDTH];
                  id_q   <= winner;
                  rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
                  state  <= EVAL;
               end
            end
            EVAL: begin
               {rsp_greater, rsp_equal, rsp_less} <= cmp_flags(cmp_a, cmp_b);
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_greater <= 1'b0;
                  rsp_equal   <= 1'b0;
                  rsp_less    <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
